// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with sequential power-on clear,
// same-cycle write bypass (highest port wins) and a per-register pending scoreboard.
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wb_clr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    clr_idx;
  logic [NREGS-1:0] pending, pending_nxt;
  logic [XLEN-1:0]  regs [NREGS];

  // Control state: reset restarts the clear walk from register 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      pending <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state   <= state_nxt;
      pending <= pending_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == AW'(NREGS - 1)) state_nxt = RUN;
  end

  assign ready = (state == RUN);

  // NOTE: the array has no reset branch; it is zeroed by the clear walk, which keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        // Later ports overwrite earlier ones, giving the highest index priority.
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
            regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard: clears first, then the issue set, so a new producer wins a collision.
  always_comb begin
    // NOTE: assigning a default first keeps combinational blocks latch-free.
    pending_nxt = pending;
    if (state == RUN) begin
      for (int j = 0; j < NWR; j++) begin
        if (wb_clr[j]) pending_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (iss_en && iss_rd != '0) pending_nxt[iss_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    if (state == RUN) begin
      for (int i = 0; i < NRD; i++) begin
        rd_pending[i] = pending[rd_addr[i*AW +: AW]];
        if (rd_addr[i*AW +: AW] != '0) begin
          rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
              rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed checks on the default configuration and a
// randomized model-based run on a 4-read/3-write, 16x64 configuration.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default configuration: XLEN=32, NREGS=32, NRD=2, NWR=2.
  logic        ready;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wb_clr;
  logic        iss_en;
  logic [4:0]  iss_rd;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wb_clr(wb_clr), .iss_en(iss_en), .iss_rd(iss_rd)
  );

  // Sweep configuration: XLEN=64, NREGS=16, NRD=4, NWR=3.
  logic         b_ready;
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_pending;
  logic [2:0]   b_wr_en;
  logic [11:0]  b_wr_addr;
  logic [191:0] b_wr_data;
  logic [2:0]   b_wb_clr;
  logic         b_iss_en;
  logic [3:0]   b_iss_rd;

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(b_ready),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_pending(b_rd_pending),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wb_clr(b_wb_clr), .iss_en(b_iss_en), .iss_rd(b_iss_rd)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    wb_clr = '0; iss_en = 1'b0; iss_rd = '0;
  endtask

  task automatic idle_b();
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_wb_clr = '0; b_iss_en = 1'b0; b_iss_rd = '0;
  endtask

  // Counts edges after reset release until the default instance reports ready.
  task automatic wait_ready_a(output int n);
    n = 0;
    while (!ready && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Reference model for the sweep instance.
  logic [63:0] mem  [16];
  bit          pend [16];
  logic [63:0] exp_d;
  logic [3:0]  ra;
  int          n;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    idle_a();
    idle_b();
    rst_n = 1'b0;
    step();
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_pending", {62'd0, rd_pending}, 64'd0);

    // Clear walk with writes/issues attempted during CLEAR; they must be ignored.
    rst_n = 1'b1;
    wr_en = 2'b11; wr_addr = {5'd6, 5'd5}; wr_data = {32'h1111_1111, 32'h2222_2222};
    iss_en = 1'b1; iss_rd = 5'd3; rd_addr = {5'd6, 5'd5};
    #1;
    check("clear_rd_data", rd_data, 64'd0);
    wait_ready_a(n);
    check("clear_cycles", 64'(n), 64'd31);
    idle_a();
    rd_addr = {5'd6, 5'd5};
    #1;
    check("clear_ignored_wr", rd_data, 64'd0);
    rd_addr = {5'd0, 5'd3};
    #1;
    check("clear_ignored_iss", {62'd0, rd_pending}, 64'd0);

    // Fill every register with 0xDEADBEEF, then reset and confirm the walk zeroes them.
    for (int r = 1; r < 32; r++) begin
      wr_en = 2'b01; wr_addr = {5'd0, 5'(r)}; wr_data = {32'd0, 32'hDEAD_BEEF};
      step();
    end
    idle_a();
    rd_addr = {5'd31, 5'd1};
    #1;
    check("fill_visible", rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    pulse_reset();
    wait_ready_a(n);
    check("reclear_cycles", 64'(n), 64'd31);
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(31 - r), 5'(r)};
      #1;
      check($sformatf("reclear_x%0d", r), rd_data, 64'd0);
    end

    // Basic write/read and the hardwired zero register.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'h1234_5678};
    step();
    idle_a();
    rd_addr = {5'd0, 5'd5};
    #1;
    check("basic_rd", {32'd0, rd_data[31:0]}, 64'h1234_5678);
    wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFF_FFFF, 32'd0};
    step();
    idle_a();
    rd_addr = {5'd0, 5'd0};
    #1;
    check("x0_zero", rd_data, 64'd0);

    // Same-address write on both ports: bypass and storage both take port 1.
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h0000_BBBB, 32'hAAAA_0000};
    rd_addr = {5'd7, 5'd5};
    #1;
    check("bypass_port1", {32'd0, rd_data[63:32]}, 64'h0000_BBBB);
    check("bypass_other_port", {32'd0, rd_data[31:0]}, 64'h1234_5678);
    step();
    idle_a();
    rd_addr = {5'd0, 5'd7};
    #1;
    check("priority_stored", {32'd0, rd_data[31:0]}, 64'h0000_BBBB);

    // Scoreboard set / collision / clear / x0.
    rd_addr = {5'd0, 5'd9};
    iss_en = 1'b1; iss_rd = 5'd9;
    #1;
    check("pend_not_bypassed", {63'd0, rd_pending[0]}, 64'd0);
    step();
    idle_a();
    rd_addr = {5'd0, 5'd9};
    #1;
    check("pend_set", {63'd0, rd_pending[0]}, 64'd1);
    wb_clr = 2'b10; wr_addr = {5'd9, 5'd0}; iss_en = 1'b1; iss_rd = 5'd9;
    step();
    idle_a();
    rd_addr = {5'd0, 5'd9};
    #1;
    check("pend_set_wins", {63'd0, rd_pending[0]}, 64'd1);
    wb_clr = 2'b10; wr_addr = {5'd9, 5'd0};
    step();
    idle_a();
    rd_addr = {5'd0, 5'd9};
    #1;
    check("pend_cleared", {63'd0, rd_pending[0]}, 64'd0);
    iss_en = 1'b1; iss_rd = 5'd0;
    step();
    idle_a();
    rd_addr = {5'd0, 5'd0};
    #1;
    check("pend_x0", {63'd0, rd_pending[0]}, 64'd0);

    // Reset mid-RUN with pending[3] set, then again at clear cycle 10.
    iss_en = 1'b1; iss_rd = 5'd3;
    step();
    idle_a();
    rd_addr = {5'd3, 5'd0};
    #1;
    check("pend3_set", {63'd0, rd_pending[1]}, 64'd1);
    pulse_reset();
    for (int k = 0; k < 10; k++) step();
    rst_n = 1'b0;
    step();
    check("midclear_ready", {63'd0, ready}, 64'd0);
    rst_n = 1'b1;
    wait_ready_a(n);
    check("midclear_cycles", 64'(n), 64'd31);
    rd_addr = {5'd3, 5'd7};
    #1;
    check("midclear_pend3", {62'd0, rd_pending}, 64'd0);
    check("midclear_regs", rd_data, 64'd0);

    // Sweep instance: random traffic against the reference model.
    n = 0;
    while (!b_ready && n < 64) begin
      step();
      n++;
    end
    check("b_ready", {63'd0, b_ready}, 64'd1);
    for (int r = 0; r < 16; r++) begin
      mem[r]  = '0;
      pend[r] = 1'b0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic       same;
      logic [3:0] base;
      same = ($urandom_range(0, 3) == 0);
      base = 4'($urandom_range(0, 15));
      b_wr_en = same ? 3'b111 : 3'($urandom_range(0, 7));
      for (int j = 0; j < 3; j++) begin
        b_wr_addr[j*4 +: 4]   = same ? base : 4'($urandom_range(0, 15));
        b_wr_data[j*64 +: 64] = {$urandom, $urandom};
      end
      b_wb_clr = 3'($urandom_range(0, 7));
      b_iss_en = 1'($urandom_range(0, 1));
      b_iss_rd = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        int pick;
        pick = int'($urandom_range(0, 2));
        b_rd_addr[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? b_wr_addr[pick*4 +: 4]
                                                         : 4'($urandom_range(0, 15));
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        ra = b_rd_addr[i*4 +: 4];
        exp_d = mem[ra];
        for (int j = 0; j < 3; j++)
          if (b_wr_en[j] && b_wr_addr[j*4 +: 4] == ra) exp_d = b_wr_data[j*64 +: 64];
        if (ra == 4'd0) exp_d = '0;
        check($sformatf("rand%0d_rd%0d", cyc, i), b_rd_data[i*64 +: 64], exp_d);
        check($sformatf("rand%0d_pend%0d", cyc, i), {63'd0, b_rd_pending[i]}, {63'd0, pend[ra]});
      end
      for (int j = 0; j < 3; j++) begin
        if (b_wr_en[j] && b_wr_addr[j*4 +: 4] != 4'd0) mem[b_wr_addr[j*4 +: 4]] = b_wr_data[j*64 +: 64];
        if (b_wb_clr[j]) pend[b_wr_addr[j*4 +: 4]] = 1'b0;
      end
      if (b_iss_en && b_iss_rd != 4'd0) pend[b_iss_rd] = 1'b1;
      step();
    end
    idle_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
